// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU bus memory responder.
//   MEM_ADDR_W  : default word-address width of the responder RAM
//   WORD_W      : default data word width
//   mem_state_t : responder FSM states
//   mem_op_t    : latched operation (read or write)
package mini_cpu_pkg;

  localparam int unsigned MEM_ADDR_W = 9;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } mem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with write enable and registered read.
//   i_clk    : clock, rising edge
//   i_rst_n  : async active-low reset, clears only the read register
//   i_we     : write i_wdata to mem[i_addr]
//   i_re     : load mem[i_addr] into o_rdata; o_rdata holds otherwise
//   i_addr   : word address
//   i_wdata  : write data
//   o_rdata  : registered read data
module mem_array
  import mini_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = WORD_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: services Read/Write strobes against MAR/MDR with
// LATENCY wait cycles and a four-phase mem_done handshake.
//   Clock     : clock, rising edge
//   clear     : async active-low reset
//   Read      : read request, level, held until mem_done
//   Write     : write request, level, held until mem_done
//   MAR_addr  : word address, sampled with the request
//   MDR_wdata : write data, sampled with the request
//   Mdatain   : registered read data, held until the next completed read
//   mem_done  : high for the single RESP cycle of each access
//   mem_busy  : high in every state except IDLE
//   mem_err   : one-cycle pulse when Read and Write arrive together
module mem_responder
  import mini_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = WORD_W,
  parameter int unsigned LATENCY = 2
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [DATA_W-1:0] MDR_wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [2:0] CNT_INIT = ZERO_LAT ? 3'd0 : 3'(LATENCY - 1);

  mem_state_t        r_state;
  mem_state_t        w_next_state;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  mem_op_t           r_op;
  logic              r_err;

  logic              w_req_one;
  logic              w_req_both;
  logic              w_req_none;
  logic              w_latch;
  logic              w_err_set;
  logic              w_enter_resp;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_clr;

  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  mem_op_t           w_acc_op;
  logic              w_we;
  logic              w_re;

  assign w_req_one  = Read ^ Write;
  assign w_req_both = Read & Write;
  assign w_req_none = ~(Read | Write);

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_err_set    = 1'b0;
    w_enter_resp = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_cnt_clr    = 1'b0;
    mem_done     = 1'b0;
    mem_busy     = 1'b1;
    unique case (r_state)
      IDLE: begin
        mem_busy = 1'b0;
        if (w_req_both) begin
          w_err_set    = 1'b1;
          w_next_state = RELEASE;
        end else if (w_req_one) begin
          w_latch = 1'b1;
          if (ZERO_LAT) begin
            w_enter_resp = 1'b1;
            w_next_state = RESP;
          end else begin
            w_cnt_load   = 1'b1;
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        // The final wait edge commits the access even if the request has
        // just been dropped; an abort only takes effect before that edge.
        if (r_cnt == 3'd0) begin
          w_enter_resp = 1'b1;
          w_next_state = RESP;
        end else if (w_req_none) begin
          w_cnt_clr    = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      RESP: begin
        mem_done     = 1'b1;
        w_next_state = RELEASE;
      end
      RELEASE: begin
        if (w_req_none) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_cnt <= '0;
    end else if (w_cnt_load) begin
      r_cnt <= CNT_INIT;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_dec) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= OP_RD;
    end else if (w_latch) begin
      r_addr  <= MAR_addr;
      r_wdata <= MDR_wdata;
      r_op    <= Write ? OP_WR : OP_RD;
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_set;
    end
  end

  assign mem_err = r_err;

  // With zero latency the access happens on the sampling edge itself, before
  // the latches are loaded, so the live bus values are routed to the array.
  assign w_acc_addr  = (r_state == IDLE) ? MAR_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? MDR_wdata : r_wdata;
  assign w_acc_op    = (r_state == IDLE) ? (Write ? OP_WR : OP_RD) : r_op;
  assign w_we        = w_enter_resp & (w_acc_op == OP_WR);
  assign w_re        = w_enter_resp & (w_acc_op == OP_RD);

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .i_clk   (Clock),
    .i_rst_n (clear),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_acc_addr),
    .i_wdata (w_acc_wdata),
    .o_rdata (Mdatain)
  );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  function automatic int unsigned lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  logic        Clock = 1'b0;
  logic        clear = 1'b0;
  logic        rq_rd [4];
  logic        rq_wr [4];
  logic [8:0]  rq_a  [4];
  logic [31:0] rq_d  [4];
  logic [31:0] mdat  [4];
  logic        done  [4];
  logic        busy  [4];
  logic        err   [4];

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clock = ~Clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(
      .ADDR_W  (9),
      .DATA_W  (32),
      .LATENCY (lat_of(g))
    ) u_dut (
      .Clock     (Clock),
      .clear     (clear),
      .Read      (rq_rd[g]),
      .Write     (rq_wr[g]),
      .MAR_addr  (rq_a[g]),
      .MDR_wdata (rq_d[g]),
      .Mdatain   (mdat[g]),
      .mem_done  (done[g]),
      .mem_busy  (busy[g]),
      .mem_err   (err[g])
    );
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d @%0t: got %h required %h", nm, i, $time, act, exp);
  endtask

  task automatic tmo(input string nm, input int i);
    n_total++;
    $display("FAIL %s inst%0d @%0t: got no response within bound, required one", nm, i, $time);
  endtask

  // ---------------- reference model ----------------
  // Each instance is either free, counting down to its commit edge, showing
  // its one done cycle, or waiting for the requester to let go.
  localparam int FREE = 0, PENDING = 1, DONE = 2, HOLD = 3;
  int          ph    [4];
  int          left  [4];
  bit          m_wr  [4];
  logic [8:0]  m_a   [4];
  logic [31:0] m_d   [4];
  bit          e_err [4];
  logic [31:0] e_rd  [4];
  bit          e_rdk [4];
  logic [31:0] mm    [4][512];
  bit          mk    [4][512];

  initial for (int i = 0; i < 4; i++) begin
    ph[i] = FREE; e_rd[i] = '0; e_rdk[i] = 1'b1; e_err[i] = 1'b0;
    rq_rd[i] = 1'b0; rq_wr[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0;
  end

  function automatic void commit(input int i);
    if (m_wr[i]) begin
      mm[i][m_a[i]] = m_d[i];
      mk[i][m_a[i]] = 1'b1;
    end else begin
      e_rd[i]  = mm[i][m_a[i]];
      e_rdk[i] = mk[i][m_a[i]];
    end
    ph[i] = DONE;
  endfunction

  always begin
    @(posedge Clock);
    for (int i = 0; i < 4; i++) begin
      bit any;
      any = rq_rd[i] || rq_wr[i];
      e_err[i] = 1'b0;
      if (!clear) begin
        ph[i] = FREE; e_rd[i] = '0; e_rdk[i] = 1'b1;
      end else if (ph[i] == FREE) begin
        if (rq_rd[i] && rq_wr[i]) begin
          e_err[i] = 1'b1; ph[i] = HOLD;
        end else if (any) begin
          m_wr[i] = rq_wr[i]; m_a[i] = rq_a[i]; m_d[i] = rq_d[i];
          left[i] = int'(lat_of(i));
          if (left[i] == 0) commit(i);
          else ph[i] = PENDING;
        end
      end else if (ph[i] == PENDING) begin
        if (left[i] == 1) commit(i);
        else if (!any) ph[i] = FREE;
        else left[i]--;
      end else if (ph[i] == DONE) begin
        ph[i] = HOLD;
      end else if (!any) begin
        ph[i] = FREE;
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("mem_done", i, 32'(done[i]), 32'(ph[i] == DONE));
      chk("mem_busy", i, 32'(busy[i]), 32'(ph[i] != FREE));
      chk("mem_err",  i, 32'(err[i]),  32'(e_err[i]));
      if (e_rdk[i]) chk("Mdatain", i, mdat[i], e_rd[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input int i, input bit rd, input bit wr, input logic [8:0] a,
                        input logic [31:0] d, input int hold_extra,
                        output int lat, output logic [31:0] rdata, output time t_raise);
    int n;
    n = 0;
    @(negedge Clock);
    while (busy[i] && n < 20) begin @(negedge Clock); n++; end
    if (busy[i]) tmo("idle_wait", i);
    rq_rd[i] = rd; rq_wr[i] = wr; rq_a[i] = a; rq_d[i] = d;
    t_raise = $time;
    @(negedge Clock);
    rq_a[i] = 9'($urandom);
    rq_d[i] = $urandom;
    lat = 1;
    while (!done[i] && lat < 20) begin @(negedge Clock); lat++; end
    if (!done[i]) begin tmo("done_wait", i); lat = -1; end
    rdata = mdat[i];
    repeat (hold_extra) begin
      @(negedge Clock);
      chk("no_second_done", i, 32'(done[i]), 32'd0);
    end
    rq_rd[i] = 1'b0; rq_wr[i] = 1'b0;
  endtask

  task automatic rand_traffic(input int i, input int n);
    repeat (n) begin
      int kind, idle, hold, guard;
      kind  = int'($urandom_range(0, 9));
      idle  = int'($urandom_range(0, 2));
      hold  = int'($urandom_range(1, lat_of(i) + 4));
      repeat (idle) @(negedge Clock);
      guard = 0;
      while (busy[i] && guard < 20) begin @(negedge Clock); guard++; end
      if (busy[i]) tmo("rand_idle_wait", i);
      rq_a[i]  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
      rq_d[i]  = $urandom;
      rq_rd[i] = (kind < 4) || (kind == 9);
      rq_wr[i] = (kind >= 4);
      repeat (hold) begin
        @(negedge Clock);
        rq_a[i] = 9'($urandom);
        rq_d[i] = $urandom;
        if (done[i]) break;
      end
      rq_rd[i] = 1'b0; rq_wr[i] = 1'b0;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] rv;
    time t1, t2;

    // Reset state
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      chk("rst_done", i, 32'(done[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_err",  i, 32'(err[i]),  32'd0);
      chk("rst_Mdatain", i, mdat[i], 32'd0);
    end
    clear = 1'b1;

    // LATENCY=2: write -12 to 0x005, read it back
    access(0, 1'b0, 1'b1, 9'h005, 32'hFFFF_FFF4, 0, lat, rv, t1);
    chk("wr_latency", 0, 32'(lat), 32'd3);
    access(0, 1'b1, 1'b0, 9'h005, 32'h0, 0, lat, rv, t1);
    chk("rd_latency", 0, 32'(lat), 32'd3);
    chk("rd_data", 0, rv, 32'hFFFF_FFF4);
    repeat (3) @(negedge Clock);
    chk("rd_hold", 0, mdat[0], 32'hFFFF_FFF4);

    // Both requests at once: rejected
    rq_rd[0] = 1'b1; rq_wr[0] = 1'b1; rq_a[0] = 9'h005; rq_d[0] = 32'h0;
    @(negedge Clock);
    chk("err_pulse", 0, 32'(err[0]), 32'd1);
    @(negedge Clock);
    chk("err_once", 0, 32'(err[0]), 32'd0);
    chk("err_busy_held", 0, 32'(busy[0]), 32'd1);
    chk("err_Mdatain", 0, mdat[0], 32'hFFFF_FFF4);
    rq_rd[0] = 1'b0; rq_wr[0] = 1'b0;
    @(negedge Clock);
    chk("err_idle", 0, 32'(busy[0]), 32'd0);
    access(0, 1'b1, 1'b0, 9'h005, 32'h0, 0, lat, rv, t1);
    chk("err_no_write", 0, rv, 32'hFFFF_FFF4);

    // LATENCY=0
    access(1, 1'b0, 1'b1, 9'h033, 32'd5, 0, lat, rv, t1);
    chk("l0_wr_latency", 1, 32'(lat), 32'd1);
    access(1, 1'b1, 1'b0, 9'h033, 32'h0, 4, lat, rv, t1);
    chk("l0_rd_latency", 1, 32'(lat), 32'd1);
    chk("l0_rd_data", 1, rv, 32'd5);

    // LATENCY=3 abort after one wait cycle
    access(2, 1'b0, 1'b1, 9'h020, 32'h0BAD_F00D, 0, lat, rv, t1);
    @(negedge Clock);
    while (busy[2]) @(negedge Clock);
    rq_wr[2] = 1'b1; rq_a[2] = 9'h020; rq_d[2] = 32'h1234;
    repeat (2) @(negedge Clock);
    rq_wr[2] = 1'b0;
    repeat (5) begin
      @(negedge Clock);
      chk("abort_no_done", 2, 32'(done[2]), 32'd0);
    end
    access(2, 1'b1, 1'b0, 9'h020, 32'h0, 0, lat, rv, t1);
    chk("abort_prior_value", 2, rv, 32'h0BAD_F00D);

    // Reset mid-WAIT of a write
    access(2, 1'b0, 1'b1, 9'h010, 32'h55, 0, lat, rv, t1);
    @(negedge Clock);
    while (busy[2]) @(negedge Clock);
    rq_wr[2] = 1'b1; rq_a[2] = 9'h010; rq_d[2] = 32'hAA;
    repeat (2) @(negedge Clock);
    clear = 1'b0; rq_wr[2] = 1'b0;
    @(negedge Clock);
    chk("clr_done", 2, 32'(done[2]), 32'd0);
    chk("clr_busy", 2, 32'(busy[2]), 32'd0);
    chk("clr_err",  2, 32'(err[2]),  32'd0);
    chk("clr_Mdatain", 2, mdat[2], 32'd0);
    clear = 1'b1;
    access(2, 1'b1, 1'b0, 9'h010, 32'h0, 0, lat, rv, t1);
    chk("clr_write_dropped", 2, 32'(rv != 32'hAA), 32'd1);
    chk("clr_old_value", 2, rv, 32'h55);

    // LATENCY=1 back-to-back, including the top address
    access(3, 1'b0, 1'b1, 9'h001, 32'hA5A5_0001, 0, lat, rv, t1);
    access(3, 1'b0, 1'b1, 9'h1FF, 32'h5A5A_01FF, 0, lat, rv, t1);
    access(3, 1'b1, 1'b0, 9'h001, 32'h0, 1, lat, rv, t1);
    chk("b2b_lat1", 3, 32'(lat), 32'd2);
    chk("b2b_data1", 3, rv, 32'hA5A5_0001);
    access(3, 1'b1, 1'b0, 9'h1FF, 32'h0, 1, lat, rv, t2);
    chk("b2b_lat2", 3, 32'(lat), 32'd2);
    chk("b2b_data2", 3, rv, 32'h5A5A_01FF);
    chk("b2b_period", 3, 32'((t2 - t1) / 10), 32'd4);

    // Randomized concurrent traffic on all instances
    for (int i = 0; i < 4; i++) begin
      fork
        automatic int ii = i;
        rand_traffic(ii, 30);
      join_none
    end
    wait fork;

    repeat (5) @(negedge Clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the mini CPU bus: services the `Read`/`Write` strobes the control unit raises against the MAR/MDR pair and returns read data on `Mdatain`, replacing the hand-driven `Mdatain` stimulus used in datapath benches. Holds a word-addressed RAM and completes each access with a configurable wait latency and a four-phase `mem_done` handshake. Sits between the datapath's MAR/MDR outputs and the MDR input mux.

## Interface
- `ADDR_W`, 9: word-address width; depth is 2^ADDR_W words.
- `DATA_W`, 32: data word width.
- `LATENCY`, 2: wait cycles inserted before the response, legal range 0..7.

- `Clock`  in  1  sole clock, rising-edge.
- `clear`  in  1  reset, asynchronous, active-low.
- `Read`  in  1  read request, level, held by the requester until `mem_done`.
- `Write`  in  1  write request, level, held by the requester until `mem_done`.
- `MAR_addr`  in  ADDR_W  word address, sampled with the request.
- `MDR_wdata`  in  DATA_W  write data, sampled with the request.
- `Mdatain`  out  DATA_W  read data, registered, held until the next completed read.
- `mem_done`  out  1  access complete; high exactly one cycle per access.
- `mem_busy`  out  1  high in every state except IDLE.
- `mem_err`  out  1  one-cycle pulse on a rejected request.

## Operation
- States: IDLE, WAIT, RESP, RELEASE.
- IDLE: on an edge with exactly one of `Read`/`Write` high, latch `MAR_addr`, `MDR_wdata`, and the operation. Go to WAIT with `cnt = LATENCY-1`; if `LATENCY = 0`, go directly to RESP.
- IDLE with `Read` and `Write` both high: no access, no latch. Pulse `mem_err` for one cycle, go to RELEASE.
- WAIT: decrement `cnt` each edge. At `cnt = 0`, go to RESP.
- WAIT with both requests low (abort): return to IDLE. No array write, `Mdatain` unchanged, no `mem_done`.
- Entering RESP, on the same edge: a read loads `mem[addr]` into `Mdatain`; a write stores the latched data into `mem[addr]`.
- RESP: `mem_done = 1` (Moore output). Go to RELEASE unconditionally.
- RELEASE: stay while `Read` or `Write` is high; go to IDLE on the first edge where both are low. A level-held request therefore never re-triggers.
- Addresses use the full ADDR_W bits with no wrap logic; the upper bits of a wider MAR are truncated by the instantiator.
- RAM contents are not affected by `clear`, and initial contents are undefined.

## Timing
- Reset (`clear` low, asynchronous): state IDLE, `cnt = 0`, `Mdatain = 0`, `mem_done = 0`, `mem_busy = 0`, `mem_err = 0`, latched address and data = 0.
- Reset during WAIT or RESP abandons the access; a pending write is not performed.
- Request sampled at edge k:
  - state becomes RESP at edge k+LATENCY;
  - `mem_done` and valid `Mdatain` appear in the cycle after that edge, giving a request-to-done latency of LATENCY+1 cycles;
  - `mem_busy` rises after edge k.
- Minimum back-to-back period: LATENCY+3 cycles (IDLE, WAIT×LATENCY, RESP, RELEASE).
- `MAR_addr` and `MDR_wdata` may change after edge k without effect.
- A request dropped in the same cycle that RESP is entered still completes.

## Structure
- Shared package `mini_cpu_pkg`:
  - the 2-bit state enum (IDLE, WAIT, RESP, RELEASE);
  - `MEM_ADDR_W` and `WORD_W` constants;
  - the op encoding (`OP_RD`, `OP_WR`).
- One sub-module, `mem_array`: single-port synchronous RAM with a write enable and a registered read. No reset on the storage.
- The FSM, counter and latches live in `mem_responder`.

## Test plan
- Reset check: hold `clear` low mid-WAIT of a write to address 0x010 with data 0x0000_00AA, then release. Required: all outputs are 0. A later read of 0x010 does not return 0xAA (a value written earlier survives).
- Write then read, LATENCY=2:
  - `Write` with address 0x005 and data 0xFFFF_FFF4 (−12), held until done → `mem_done` 3 cycles after the sampling edge.
  - `Read` of 0x005 → `Mdatain = 0xFFFF_FFF4` together with `mem_done`; `Mdatain` holds afterwards.
- LATENCY=0 instance: `Read` of a location holding 32'd5 → `mem_done` and `Mdatain = 5` in the cycle after the sampling edge. `Read` kept high 4 more cycles → no second `mem_done`.
- `Read` and `Write` both high in IDLE → `mem_err` pulses once. No array change and `Mdatain` unchanged. After both drop, IDLE is reached and `mem_busy = 0`.
- Abort: `Write` of 0x1234 to 0x020 dropped after 1 WAIT cycle (LATENCY=3) → no `mem_done`, and a read of 0x020 returns its prior value.
- Back-to-back reads of 0x001 and 0x1FF (top address), LATENCY=1, with the request dropped the cycle after each done → each completes in 2 cycles, the second request starts at the earliest after RELEASE, and both values are returned.
